// File: rtl/r88_intctl_if.sv
// r88_intctl_if: core-side register bus of the Rocket88 interrupt/reset
// controller (address, write data, read/write strobes, read data and the
// drive enable for the board-level extD tristate).
interface r88_intctl_if;
    logic [15:0] extA;
    logic [7:0]  extDIn;
    logic        readMem;
    logic        writeMem;
    logic [7:0]  dataOut;
    logic        dataOe;

    modport master (
        output extA, extDIn, readMem, writeMem,
        input  dataOut, dataOe
    );

    modport slave (
        input  extA, extDIn, readMem, writeMem,
        output dataOut, dataOe
    );
endinterface

// File: rtl/r88_intctl.sv
// r88_intctl: interrupt and reset controller in front of the Rocket88 core.
// Synchronises board reset, NMI and eight interrupt sources, stretches reset,
// masks/prioritises interrupts and exposes an 8-byte register window:
//   +0 PENDING (ro)  +1 MASK (rw)  +2 ACK (wo, w1c)  +3 VECTOR (ro)
//   +4 EDGE (rw only with R88_INTCTL_EDGE_EN)  +5..+7 reserved (read 0)
// Define R88_INTCTL_EDGE_EN to build the per-source edge-latch mode; without
// it every source is level-sensitive and ACK writes are ignored.
module r88_intctl #(
    parameter logic [15:0] BASE_ADDR    = 16'hFF00,
    parameter int          RESET_CYCLES = 16
) (
    input  logic       i_sysClock,
    input  logic       i_resetN,
    input  logic [7:0] i_irqSrc,
    input  logic       i_nmiSrc,
    r88_intctl_if.slave bus,
    output logic       o_resetReq,
    output logic       o_nmiReq,
    output logic       o_irq
);
    localparam logic [7:0] LP_RST_TC = 8'(RESET_CYCLES);

    logic [1:0] r_rst_sync;
    logic [7:0] r_cnt;
    logic [7:0] w_cnt_next;
    logic       r_reset_req;

    logic [7:0] r_irq_s1, r_irq_s2;
    logic       r_nmi_s1, r_nmi_s2, r_nmi_s3;
    logic       r_nmi_edge, r_nmi_req;

    logic [7:0] r_pend, r_mask;
    logic [7:0] w_pend_next;
    logic [7:0] w_act;
    logic [7:0] w_vector;
    logic [7:0] w_rdata;
    logic       r_irq;

    logic       w_hit;
    logic [2:0] w_off;
    logic       w_wr;

    assign w_hit = (bus.extA[15:3] == BASE_ADDR[15:3]);
    assign w_off = bus.extA[2:0];
    // Writes are dropped while the core is still held in reset.
    assign w_wr  = bus.writeMem & w_hit & ~r_reset_req;
    assign w_act = r_pend & r_mask;

    assign w_cnt_next = (r_rst_sync[1] && (r_cnt != LP_RST_TC)) ? r_cnt + 8'd1 : r_cnt;

    // Reset release synchroniser and stretch counter; resetReq drops on terminal count.
    always_ff @(posedge i_sysClock or negedge i_resetN) begin
        if (!i_resetN) begin
            r_rst_sync  <= 2'b00;
            r_cnt       <= 8'd0;
            r_reset_req <= 1'b1;
        end else begin
            r_rst_sync  <= {r_rst_sync[0], 1'b1};
            r_cnt       <= w_cnt_next;
            r_reset_req <= (w_cnt_next != LP_RST_TC);
        end
    end

    // Input synchronisers and NMI edge-to-pulse; the extra stage aligns the pulse with the core.
    always_ff @(posedge i_sysClock or negedge i_resetN) begin
        if (!i_resetN) begin
            r_irq_s1   <= 8'h00;
            r_irq_s2   <= 8'h00;
            r_nmi_s1   <= 1'b0;
            r_nmi_s2   <= 1'b0;
            r_nmi_s3   <= 1'b0;
            r_nmi_edge <= 1'b0;
            r_nmi_req  <= 1'b0;
        end else begin
            r_irq_s1   <= i_irqSrc;
            r_irq_s2   <= r_irq_s1;
            r_nmi_s1   <= i_nmiSrc;
            r_nmi_s2   <= r_nmi_s1;
            r_nmi_s3   <= r_nmi_s2;
            r_nmi_edge <= r_nmi_s2 & ~r_nmi_s3 & ~r_reset_req;
            r_nmi_req  <= r_nmi_edge & ~r_reset_req;
        end
    end

`ifdef R88_INTCTL_EDGE_EN
    logic [7:0] r_irq_s3;
    logic [7:0] r_edge;
    logic [7:0] w_rise;
    logic [7:0] w_ack;

    assign w_rise = r_irq_s2 & ~r_irq_s3;
    assign w_ack  = (w_wr && (w_off == 3'd2)) ? bus.extDIn : 8'h00;
    // Edge bits latch rising edges (set beats ACK clear); level bits track the synchroniser.
    assign w_pend_next = (r_edge & ((r_pend & ~w_ack) | w_rise)) | (~r_edge & r_irq_s2);

    // Edge-detect delay stage and EDGE register.
    always_ff @(posedge i_sysClock or negedge i_resetN) begin
        if (!i_resetN) begin
            r_irq_s3 <= 8'h00;
            r_edge   <= 8'h00;
        end else begin
            r_irq_s3 <= r_irq_s2;
            if (w_wr && (w_off == 3'd4)) begin
                r_edge <= bus.extDIn;
            end
        end
    end
`else
    assign w_pend_next = r_irq_s2;
`endif

    // PENDING, MASK and the registered interrupt request.
    always_ff @(posedge i_sysClock or negedge i_resetN) begin
        if (!i_resetN) begin
            r_pend <= 8'h00;
            r_mask <= 8'h00;
            r_irq  <= 1'b0;
        end else begin
            r_pend <= w_pend_next;
            if (w_wr && (w_off == 3'd1)) begin
                r_mask <= bus.extDIn;
            end
            r_irq <= (|w_act) & ~r_reset_req;
        end
    end

    // Priority encoder: lowest-numbered active source wins, 0x80 when idle.
    always_comb begin
        w_vector = 8'h80;
        for (int k = 7; k >= 0; k--) begin
            if (w_act[k]) begin
                w_vector = {5'b00000, 3'(k)};
            end
        end
    end

    // Register read mux.
    always_comb begin
        w_rdata = 8'h00;
        case (w_off)
            3'd0:    w_rdata = r_pend;
            3'd1:    w_rdata = r_mask;
            3'd3:    w_rdata = w_vector;
`ifdef R88_INTCTL_EDGE_EN
            3'd4:    w_rdata = r_edge;
`endif
            default: w_rdata = 8'h00;
        endcase
    end

    assign bus.dataOut = w_hit ? w_rdata : 8'h00;
    assign bus.dataOe  = bus.readMem & ~bus.writeMem & w_hit;

    assign o_resetReq = r_reset_req;
    assign o_nmiReq   = r_nmi_req;
    assign o_irq      = r_irq;
endmodule

// File: tb/tb_r88_intctl.sv
// Directed bench for r88_intctl: reset stretch, level interrupts and vector,
// edge-latch mode (when built with R88_INTCTL_EDGE_EN), NMI pulses, register
// window decode and asynchronous reset mid-operation.
module tb_r88_intctl;
    localparam logic [15:0] BASE = 16'hFF00;

    logic       sysClock;
    logic       resetN;
    logic [7:0] irqSrc;
    logic       nmiSrc;
    logic       resetReq, nmiReq, irq;

    int n_checks = 0;
    int n_fail   = 0;

    r88_intctl_if bus ();

    r88_intctl #(.BASE_ADDR(BASE), .RESET_CYCLES(16)) dut (
        .i_sysClock (sysClock),
        .i_resetN   (resetN),
        .i_irqSrc   (irqSrc),
        .i_nmiSrc   (nmiSrc),
        .bus        (bus),
        .o_resetReq (resetReq),
        .o_nmiReq   (nmiReq),
        .o_irq      (irq)
    );

    initial begin
        sysClock = 1'b0;
        forever #5 sysClock = ~sysClock;
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge sysClock);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic bus_write(input logic [15:0] addr, input logic [7:0] data);
        bus.extA     = addr;
        bus.extDIn   = data;
        bus.writeMem = 1'b1;
        tick();
        bus.writeMem = 1'b0;
    endtask

    task automatic bus_read(input string tag, input logic [15:0] addr,
                            input logic [7:0] exp_data, input logic exp_oe);
        bus.extA    = addr;
        bus.readMem = 1'b1;
        #1;
        check({tag, "_oe"}, bus.dataOe, exp_oe);
        check({tag, "_data"}, bus.dataOut, exp_data);
        bus.readMem = 1'b0;
        #1;
    endtask

    initial begin
        resetN       = 1'b0;
        irqSrc       = 8'hFF;
        nmiSrc       = 1'b0;
        bus.extA     = 16'h0000;
        bus.extDIn   = 8'h00;
        bus.readMem  = 1'b0;
        bus.writeMem = 1'b0;

        // Reset state
        ticks(3);
        check("rst_resetReq", resetReq, 1'b1);
        check("rst_nmiReq", nmiReq, 1'b0);
        check("rst_irq", irq, 1'b0);
        check("rst_dataOe", bus.dataOe, 1'b0);
        bus_read("rst_mask", BASE + 16'd1, 8'h00, 1'b1);

        // Release: resetReq high for 18 edges; writes and NMI edges blocked meanwhile
        tick();
        resetN       = 1'b1;
        nmiSrc       = 1'b1;
        bus.extA     = BASE + 16'd1;
        bus.extDIn   = 8'hFF;
        bus.writeMem = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            tick();
            check("stretch_resetReq", resetReq, 1'b1);
            check("stretch_irq", irq, 1'b0);
            check("stretch_nmiReq", nmiReq, 1'b0);
        end
        bus.writeMem = 1'b0;
        tick();
        check("stretch_release", resetReq, 1'b0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("post_rst_nmiReq", nmiReq, 1'b0);
            check("post_rst_irq", irq, 1'b0);
        end
        bus_read("mask_after_blocked_write", BASE + 16'd1, 8'h00, 1'b1);
        nmiSrc = 1'b0;
        irqSrc = 8'h00;
        ticks(4);

        // Level interrupts, masking and vector
        bus_write(BASE + 16'd1, 8'h0C);
        irqSrc = 8'h08;
        ticks(3);
        check("irq_rise_3", irq, 1'b0);
        tick();
        check("irq_rise_4", irq, 1'b1);
        bus_read("vector_3", BASE + 16'd3, 8'h03, 1'b1);
        bus_read("pending_08", BASE + 16'd0, 8'h08, 1'b1);
        irqSrc = 8'h0C;
        ticks(4);
        bus_read("vector_2", BASE + 16'd3, 8'h02, 1'b1);
        bus_write(BASE + 16'd1, 8'h08);
        bus_read("vector_masked", BASE + 16'd3, 8'h03, 1'b1);
        irqSrc = 8'h00;
        ticks(3);
        check("irq_fall_3", irq, 1'b1);
        tick();
        check("irq_fall_4", irq, 1'b0);
        bus_read("vector_none", BASE + 16'd3, 8'h80, 1'b1);
        bus_read("ack_reads_0", BASE + 16'd2, 8'h00, 1'b1);

        // MASK write reaches irq one edge after the write edge
        irqSrc = 8'h10;
        ticks(4);
        check("irq_unmasked_src", irq, 1'b0);
        bus_write(BASE + 16'd1, 8'h10);
        check("mask_write_edge", irq, 1'b0);
        tick();
        check("mask_write_next", irq, 1'b1);
        irqSrc = 8'h00;
        ticks(4);

`ifdef R88_INTCTL_EDGE_EN
        // Edge mode on source 0
        bus_write(BASE + 16'd4, 8'h01);
        bus_write(BASE + 16'd1, 8'h01);
        bus_read("edge_reg", BASE + 16'd4, 8'h01, 1'b1);
        irqSrc = 8'h01;
        ticks(3);
        irqSrc = 8'h00;
        ticks(5);
        bus_read("edge_latched", BASE + 16'd0, 8'h01, 1'b1);
        check("edge_irq", irq, 1'b1);
        bus_write(BASE + 16'd2, 8'h01);
        bus_read("edge_acked", BASE + 16'd0, 8'h00, 1'b1);
        tick();
        check("edge_irq_clear", irq, 1'b0);
        // ACK coinciding with a new rising edge: set wins
        irqSrc = 8'h01;
        ticks(2);
        bus_write(BASE + 16'd2, 8'h01);
        bus_read("ack_vs_set", BASE + 16'd0, 8'h01, 1'b1);
        irqSrc = 8'h00;
        ticks(4);
        bus_read("edge_still_set", BASE + 16'd0, 8'h01, 1'b1);
        bus_write(BASE + 16'd2, 8'h01);
        bus_read("clean_ack", BASE + 16'd0, 8'h00, 1'b1);
        check("clean_ack_irq_hold", irq, 1'b1);
        tick();
        check("clean_ack_irq_drop", irq, 1'b0);
        bus_write(BASE + 16'd4, 8'h00);
`else
        // Without the edge option: EDGE reads 0 and ACK has no effect
        bus_write(BASE + 16'd4, 8'h01);
        bus_read("edge_reg_absent", BASE + 16'd4, 8'h00, 1'b1);
        bus_write(BASE + 16'd1, 8'h01);
        irqSrc = 8'h01;
        ticks(3);
        irqSrc = 8'h00;
        ticks(5);
        bus_read("level_pulse_gone", BASE + 16'd0, 8'h00, 1'b1);
        check("level_pulse_irq", irq, 1'b0);
        irqSrc = 8'h01;
        ticks(4);
        bus_write(BASE + 16'd2, 8'h01);
        bus_read("ack_ignored", BASE + 16'd0, 8'h01, 1'b1);
        tick();
        check("ack_ignored_irq", irq, 1'b1);
        irqSrc = 8'h00;
        ticks(4);
`endif

        // NMI: one pulse on the 4th edge per rising edge
        nmiSrc = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            check("nmi_pulse1", nmiReq, (k == 4));
        end
        nmiSrc = 1'b0;
        ticks(5);
        nmiSrc = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            check("nmi_pulse2", nmiReq, (k == 4));
        end
        nmiSrc = 1'b0;
        ticks(4);

        // Register window decode
        bus_write(BASE + 16'd1, 8'h5A);
        bus_read("mask_5a", BASE + 16'd1, 8'h5A, 1'b1);
        bus_read("miss_above", BASE + 16'd8, 8'h00, 1'b0);
        bus_read("miss_below", BASE - 16'd1, 8'h00, 1'b0);
        bus_read("reserved_5", BASE + 16'd5, 8'h00, 1'b1);
        bus_write(BASE + 16'd6, 8'hFF);
        bus_read("reserved_6", BASE + 16'd6, 8'h00, 1'b1);
        bus.extA     = BASE + 16'd1;
        bus.extDIn   = 8'h33;
        bus.readMem  = 1'b1;
        bus.writeMem = 1'b1;
        #1;
        check("rdwr_dataOe", bus.dataOe, 1'b0);
        tick();
        bus.readMem  = 1'b0;
        bus.writeMem = 1'b0;
        bus_read("rdwr_wrote", BASE + 16'd1, 8'h33, 1'b1);

        // Asynchronous reset mid-operation
        bus_write(BASE + 16'd1, 8'h01);
        irqSrc = 8'h01;
        ticks(4);
        check("pre_arst_irq", irq, 1'b1);
        nmiSrc = 1'b1;
        ticks(4);
        check("pre_arst_nmi", nmiReq, 1'b1);
        #2;
        resetN = 1'b0;
        #1;
        check("arst_resetReq", resetReq, 1'b1);
        check("arst_nmiReq", nmiReq, 1'b0);
        check("arst_irq", irq, 1'b0);
        check("arst_dataOe", bus.dataOe, 1'b0);
        tick();
        resetN = 1'b1;
        ticks(18);
        check("recover_resetReq", resetReq, 1'b0);
        bus_read("recover_mask", BASE + 16'd1, 8'h00, 1'b1);
        ticks(2);
        check("recover_irq", irq, 1'b0);
        check("recover_nmi", nmiReq, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
